// File: rtl/ifetch.sv
// Instruction fetch: Wishbone read master feeding a two-entry queue
// that presents {inst, pc, fault} to decode with a valid/stall handshake.
module ifetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        goto_i,
    input  logic [63:0] newpc_i,
    input  logic        stall_i,
    output logic [63:0] iadr_o,
    output logic        icyc_o,
    output logic        istb_o,
    input  logic        iack_i,
    input  logic        ierr_i,
    input  logic [31:0] idat_i,
    output logic [31:0] inst_o,
    output logic        inst_en_o,
    output logic [63:0] pc_o,
    output logic        ifault_o
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_HALT
    } state_t;

    state_t      r_state, w_state_n;
    logic [63:0] r_pc, w_pc_n;
    logic [63:0] r_adr, w_adr_n;
    logic        r_discard, w_disc_n;
    logic [1:0]  r_cnt, w_cnt_pop, w_cnt_n;

    logic [31:0] r_i0, r_i1, w_i0, w_i1;
    logic [63:0] r_p0, r_p1, w_p0, w_p1;
    logic        r_f0, r_f1, w_f0, w_f1;

    logic        w_pop, w_term, w_push;
    logic [63:0] w_goto_pc;
    logic        w_unused;

    assign w_unused  = ^newpc_i[1:0];
    assign w_goto_pc = {newpc_i[63:2], 2'b00};
    assign w_pop     = (r_cnt != 2'd0) && !stall_i;
    assign w_term    = (r_state == S_BUS) && (iack_i || ierr_i);
    assign w_push    = w_term && !r_discard && !goto_i;
    assign w_cnt_pop = r_cnt - {1'b0, w_pop};
    assign w_cnt_n   = goto_i ? 2'd0 : w_cnt_pop + {1'b0, w_push};

    // Slots past the count always hold NOP/0/0 so the head can drive outputs directly.
    always_comb begin
        w_i0 = w_pop ? r_i1 : r_i0;
        w_p0 = w_pop ? r_p1 : r_p0;
        w_f0 = w_pop ? r_f1 : r_f0;
        w_i1 = w_pop ? NOP : r_i1;
        w_p1 = w_pop ? 64'd0 : r_p1;
        w_f1 = w_pop ? 1'b0 : r_f1;
        if (w_push) begin
            if (w_cnt_pop == 2'd0) begin
                w_i0 = ierr_i ? NOP : idat_i;
                w_p0 = r_adr;
                w_f0 = ierr_i;
            end else begin
                w_i1 = ierr_i ? NOP : idat_i;
                w_p1 = r_adr;
                w_f1 = ierr_i;
            end
        end
        if (goto_i) begin
            w_i0 = NOP;
            w_p0 = 64'd0;
            w_f0 = 1'b0;
            w_i1 = NOP;
            w_p1 = 64'd0;
            w_f1 = 1'b0;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_pc_n    = r_pc;
        w_adr_n   = r_adr;
        w_disc_n  = r_discard;
        if (goto_i) begin
            w_pc_n = w_goto_pc;
            if ((r_state == S_BUS) && !w_term) begin
                w_disc_n = 1'b1;
            end else begin
                w_disc_n  = 1'b0;
                w_state_n = S_BUS;
                w_adr_n   = w_goto_pc;
            end
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_cnt_n <= 2'd1) begin
                        w_state_n = S_BUS;
                        w_adr_n   = r_pc;
                    end
                end
                S_BUS: begin
                    if (w_term) begin
                        if (r_discard) begin
                            // pc already holds the redirect target
                            w_disc_n = 1'b0;
                            if (w_cnt_n <= 2'd1) begin
                                w_adr_n = r_pc;
                            end else begin
                                w_state_n = S_IDLE;
                            end
                        end else if (ierr_i) begin
                            w_state_n = S_HALT;
                        end else begin
                            w_pc_n = r_adr + 64'd4;
                            if (w_cnt_n <= 2'd1) begin
                                w_adr_n = r_adr + 64'd4;
                            end else begin
                                w_state_n = S_IDLE;
                            end
                        end
                    end
                end
                S_HALT: begin
                    w_state_n = S_HALT;
                end
                default: begin
                    w_state_n = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_adr     <= 64'd0;
            r_discard <= 1'b0;
            r_cnt     <= 2'd0;
            r_i0      <= NOP;
            r_p0      <= 64'd0;
            r_f0      <= 1'b0;
            r_i1      <= NOP;
            r_p1      <= 64'd0;
            r_f1      <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_pc      <= w_pc_n;
            r_adr     <= w_adr_n;
            r_discard <= w_disc_n;
            r_cnt     <= w_cnt_n;
            r_i0      <= w_i0;
            r_p0      <= w_p0;
            r_f0      <= w_f0;
            r_i1      <= w_i1;
            r_p1      <= w_p1;
            r_f1      <= w_f1;
        end
    end

    assign icyc_o    = (r_state == S_BUS);
    assign istb_o    = (r_state == S_BUS);
    assign iadr_o    = r_adr;
    assign inst_o    = r_i0;
    assign pc_o      = r_p0;
    assign ifault_o  = r_f0;
    assign inst_en_o = (r_cnt != 2'd0);
endmodule
